// File: rtl/ifu.sv
// ifu: MIPS program counter, next-PC select, fetch address check and IF/ID register
module ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_4FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_is_jump,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [4:0]  id_exccode,
  output logic        id_bd,
  output logic        id_valid
);
  logic [31:0] pc;
  logic        fault;
  assign imem_addr = pc;
  assign fault = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (exc_req) pc <= HANDLER_PC;
    else if (eret) pc <= epc;
    else if (!stall) pc <= redirect ? redirect_pc : pc + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (reset || exc_req || eret) begin
      id_instr   <= '0;
      id_pc      <= '0;
      id_pc8     <= '0;
      id_exccode <= '0;
      id_bd      <= 1'b0;
      id_valid   <= 1'b0;
    end else if (!stall) begin
      id_instr   <= fault ? 32'd0 : imem_data;
      id_pc      <= pc;
      id_pc8     <= pc + 32'd8;
      id_exccode <= fault ? 5'd4 : 5'd0;
      id_bd      <= id_is_jump;
      id_valid   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu against a behavioural fetch model
module tb_ifu;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } obs_t;

  logic        clk = 0;
  logic        reset = 0, stall = 0, redirect = 0, id_is_jump = 0, exc_req = 0, eret = 0;
  logic [31:0] redirect_pc = 0, epc = 0;
  logic [31:0] imem_addr, imem_data, id_instr, id_pc, id_pc8;
  logic [4:0]  id_exccode;
  logic        id_bd, id_valid;

  int checks = 0, errors = 0;
  obs_t sb[$];
  longint m_pc;
  obs_t m_id;
  bit started = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2401_0001;
  endfunction

  function automatic bit legal(input longint a);
    return (a % 4 == 0) && a >= 'h3000 && a <= 'h4FFC;
  endfunction

  assign imem_data = mem(imem_addr);

  ifu dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_is_jump(id_is_jump), .exc_req(exc_req),
    .eret(eret), .epc(epc), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8), .id_exccode(id_exccode),
    .id_bd(id_bd), .id_valid(id_valid)
  );

  task automatic cyc(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                     input bit jmp, input bit ex, input bit er, input logic [31:0] e);
    obs_t x;
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    id_is_jump = jmp; exc_req = ex; eret = er; epc = e;
    if (rst) begin
      m_pc = 'h3000;
      m_id = '0;
      started = 1;
    end else if (started) begin
      if (ex || er) m_id = '0;
      else if (!st) begin
        m_id.instr = legal(m_pc) ? mem(32'(m_pc)) : 32'd0;
        m_id.exc   = legal(m_pc) ? 5'd0 : 5'd4;
        m_id.pc    = 32'(m_pc);
        m_id.pc8   = 32'((m_pc + 8) % (64'd1 << 32));
        m_id.bd    = jmp;
        m_id.valid = 1;
      end
      if (ex) m_pc = 'h4180;
      else if (er) m_pc = e;
      else if (!st) m_pc = rd ? rpc : (m_pc + 4) % (64'd1 << 32);
    end
    if (started) begin
      x = m_id;
      x.addr = 32'(m_pc);
      sb.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      obs_t e, g;
      e = sb.pop_front();
      g = '{imem_addr, id_instr, id_pc, id_pc8, id_exccode, id_bd, id_valid};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL fetch_state got addr=%h instr=%h pc=%h pc8=%h exc=%0d bd=%b v=%b exp addr=%h instr=%h pc=%h pc8=%h exc=%0d bd=%b v=%b",
          g.addr, g.instr, g.pc, g.pc8, g.exc, g.bd, g.valid,
          e.addr, e.instr, e.pc, e.pc8, e.exc, e.bd, e.valid);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'h3100, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'h3102, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'h5000, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'h2FFC, 1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 1, 32'h3200, 1, 1, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h3020);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h3020);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h3300, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'h4FFC, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: tgt = 32'h3102;
        1: tgt = 32'h5000;
        2: tgt = 32'h2FFC;
        default: tgt = 32'h3000 + ($urandom_range(0, 32'h7FF) << 2);
      endcase
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, tgt,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
          32'h3000 + ($urandom_range(0, 32'h7FF) << 2));
    end
    idle(1);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the five-stage MIPS pipeline. Holds the program counter, drives the fetch address into the combinational instruction memory, selects the next PC (sequential, branch/jump redirect, exception entry, eret return), checks the fetch address, and registers the fetched word into the IF/ID pipeline register with stall and flush control. Sits between the CP0/ID-stage control and the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- HANDLER_PC, 32'h0000_4180, exception entry address
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_4FFC, highest legal fetch address

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall from ID: hold PC and IF/ID
- redirect  in  1  ID resolved a taken branch/jump this cycle
- redirect_pc  in  32  target for redirect
- id_is_jump  in  1  instruction currently in ID is a branch/jump (taken or not)
- exc_req  in  1  CP0 takes an exception/interrupt this cycle
- eret  in  1  eret committing this cycle
- epc  in  32  return address for eret
- imem_addr  out  32  fetch address (= PC register, combinational)
- imem_data  in  32  instruction word, valid same cycle
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC
- id_pc8  out  32  IF/ID PC+8 (link value)
- id_exccode  out  5  fetch exception code: 0 none, 4 AdEL
- id_bd  out  1  IF/ID instruction is a branch delay slot
- id_valid  out  1  IF/ID holds a real fetch (0 = bubble)

## Operation

- PC register update priority (highest first): reset → RESET_PC; exc_req → HANDLER_PC; eret → epc; stall → hold; redirect → redirect_pc; else PC+4 (mod 2^32).
- IF/ID update priority: reset → clear; exc_req or eret → flush; stall → hold; else load fetch.
- Clear/flush value: id_instr=0 (nop), id_pc=0, id_pc8=0, id_exccode=0, id_bd=0, id_valid=0.
- Load: id_pc=PC, id_pc8=PC+8, id_valid=1, id_bd=id_is_jump.
- Address check on PC: PC[1:0]!=0 or PC<TEXT_LO or PC>TEXT_HI → id_instr=0, id_exccode=4; otherwise id_instr=imem_data, id_exccode=0. Faulting PC is still recorded in id_pc; PC still advances per priority (CP0 redirects via exc_req later).
- Comparisons unsigned, 32-bit.
- exc_req and eret both high: exc_req wins.
- redirect with stall: stall wins; ID re-asserts redirect when unstalled.
- redirect_pc/epc are not checked here; a bad target faults at its own fetch.

## Timing

- Reset: PC=RESET_PC and all IF/ID outputs at flush value on the first edge with reset=1; imem_addr=0x3000 the following cycle.
- imem_addr changes only at clock edges; imem_data sampled same cycle (zero-latency memory).
- Fetch latency: word at PC in cycle n appears on id_* in cycle n+1.
- Branch: redirect in cycle n (branch in ID); delay slot at PC+4 is fetched in cycle n and enters ID at n+1 with id_bd=1; target fetched in n+1.
- Exception: exc_req in cycle n → IF/ID bubble and PC=HANDLER_PC at n+1; handler word in ID at n+2. eret identical with epc.
- Stall: all state held for every cycle stall=1 (unless exc_req/eret/reset).
- reset mid-stall or mid-redirect: reset wins, everything reinitialised.

## Test plan

- Reset, then 4 free-running cycles, memory returning 0x24010001.. → imem_addr 0x3000,0x3004,0x3008,0x300C; id_pc lags by one cycle, id_pc8 = id_pc+8, id_valid=1, id_bd=0.
- stall=1 for 3 cycles at PC=0x3008 → imem_addr and all id_* frozen; release → fetch resumes at 0x300C.
- id_is_jump=1 and redirect=1, redirect_pc=0x3100 with PC=0x3010 → next cycle id_pc=0x3010, id_bd=1; imem_addr=0x3100; following id_pc=0x3100, id_bd=0.
- redirect_pc=0x3102 → next fetch id_instr=0, id_exccode=4, id_pc=0x3102; same for redirect_pc=0x5000 and 0x2FFC.
- exc_req with stall=1 and redirect=1 simultaneously → id_valid=0, id_instr=0, PC=0x4180; next cycle id_pc=0x4180. Repeat with exc_req+eret together → 0x4180.
- eret with epc=0x3020 → bubble in ID, then id_pc=0x3020; reset asserted during a stall → PC=0x3000, id_valid=0.
